// File: rtl/layer_compositor.sv
// layer_compositor
//   Final compositing stage behind the character sprite stage. Merges the
//   character layer, the obstacle layer and a flat background into the 12-bit
//   VGA colour. It also detects character/obstacle overlap, runs the game
//   state machine RUN -> HIT -> OVER and keeps a per-frame score.
//
//   There is no handshake: one pixel is accepted every clock and its colour
//   appears on vga_* exactly one clock later.
//
//   Optional build macro HIGH_SCORE_EN adds the high_score output and register.
//
// Ports
//   clock, reset                  pixel clock, asynchronous active-high reset
//   display_col, display_row      current raster position
//   visible                       active-video flag
//   char_red/green/blue, char_visible   character layer colour + opacity
//   obst_red/green/blue, obst_visible   obstacle layer colour + opacity
//   restart_key                   restart request, honoured only in OVER
//   vga_red/green/blue            registered output colour
//   collision                     one-clock pulse on the first overlap of a run
//   game_over                     high while in OVER
//   score                         frames survived (saturating)
//   high_score                    best final score (HIGH_SCORE_EN only)
module layer_compositor #(
    parameter logic [11:0] BG_COLOR         = 12'hFFF,
    parameter int          HIT_FLASH_FRAMES = 30,
    parameter int          SCORE_W          = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [11:0]        display_col,
    input  logic [10:0]        display_row,
    input  logic               visible,
    input  logic [3:0]         char_red,
    input  logic [3:0]         char_green,
    input  logic [3:0]         char_blue,
    input  logic               char_visible,
    input  logic [3:0]         obst_red,
    input  logic [3:0]         obst_green,
    input  logic [3:0]         obst_blue,
    input  logic               obst_visible,
    input  logic               restart_key,
    output logic [3:0]         vga_red,
    output logic [3:0]         vga_green,
    output logic [3:0]         vga_blue,
    output logic               collision,
    output logic               game_over,
`ifdef HIGH_SCORE_EN
    output logic [SCORE_W-1:0] high_score,
`endif
    output logic [SCORE_W-1:0] score
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HIT  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam logic [7:0] FLASH_LOAD = 8'(HIT_FLASH_FRAMES);

    state_t             state, state_nxt;
    logic               origin, origin_d, fs, overlap, flash_on;
    logic [7:0]         flash_cnt, flash_nxt;
    logic [SCORE_W-1:0] score_nxt;
    logic               collision_nxt;
    logic [3:0]         red_nxt, green_nxt, blue_nxt;

    // A frame start is the rising edge of the raster origin, so holding
    // (0,0) for several clocks still yields a single fs.
    assign origin    = (display_col == 12'd0) && (display_row == 11'd0);
    assign fs        = origin && !origin_d;
    assign overlap   = visible && char_visible && obst_visible;
    assign game_over = (state == ST_OVER);
    // Flash is driven by bit 2 of the remaining-frame count, HIT only.
    assign flash_on  = (state == ST_HIT) && flash_cnt[2];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        flash_nxt     = flash_cnt;
        score_nxt     = score;
        collision_nxt = 1'b0;
        case (state)
            ST_RUN: begin
                // Score and overlap are independent: both may act on one clock.
                if (fs && (score != '1)) score_nxt = score + SCORE_W'(1);
                if (overlap) begin
                    collision_nxt = 1'b1;
                    flash_nxt     = FLASH_LOAD;
                    state_nxt     = ST_HIT;
                end
            end
            ST_HIT: begin
                if (fs) begin
                    flash_nxt = flash_cnt - 8'd1;
                    if (flash_cnt == 8'd1) state_nxt = ST_OVER;
                end
            end
            ST_OVER: begin
                if (restart_key) begin
                    state_nxt = ST_RUN;
                    score_nxt = '0;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        red_nxt   = 4'h0;
        green_nxt = 4'h0;
        blue_nxt  = 4'h0;
        if (!visible) begin
            red_nxt = 4'h0;
        end else if (char_visible) begin
            if (flash_on) begin
                red_nxt = 4'hF;
            end else begin
                red_nxt   = char_red;
                green_nxt = char_green;
                blue_nxt  = char_blue;
            end
        end else if (obst_visible) begin
            red_nxt   = obst_red;
            green_nxt = obst_green;
            blue_nxt  = obst_blue;
        end else begin
            red_nxt   = BG_COLOR[3:0];
            green_nxt = BG_COLOR[7:4];
            blue_nxt  = BG_COLOR[11:8];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            origin_d  <= 1'b0;
            flash_cnt <= 8'd0;
            score     <= '0;
            collision <= 1'b0;
            vga_red   <= 4'h0;
            vga_green <= 4'h0;
            vga_blue  <= 4'h0;
        end else begin
            origin_d  <= origin;
            flash_cnt <= flash_nxt;
            score     <= score_nxt;
            collision <= collision_nxt;
            vga_red   <= red_nxt;
            vga_green <= green_nxt;
            vga_blue  <= blue_nxt;
        end
    end

`ifdef HIGH_SCORE_EN
    // Captured on the clock that enters OVER; the score is already frozen then.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            high_score <= '0;
        end else if ((state != ST_OVER) && (state_nxt == ST_OVER) &&
                     (score > high_score)) begin
            high_score <= score;
        end
    end
`endif

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Stage directly downstream of the character sprite stage. Merges character pixels, obstacle pixels and a flat background into the final 12-bit VGA colour.
- Detects character/obstacle pixel overlap and runs the game-state machine RUN -> HIT -> OVER.
- Keeps a per-frame score. Outputs feed the VGA DAC pins and the HUD/score display.

Parameters:
- BG_COLOR, 12'hFFF, background colour {blue[11:8], green[7:4], red[3:0]}; same packing as the sprite ROMs.
- HIT_FLASH_FRAMES, 30, number of frames spent in HIT before OVER; range 1..255.
- SCORE_W, 16, width of the score counter.

Ports:
- clock  input  1  pixel clock
- reset  input  1  asynchronous, active-high
- display_col  input  12  current pixel column
- display_row  input  11  current pixel row
- visible  input  1  active-video flag
- char_red, char_green, char_blue  input  4 each  character layer colour
- char_visible  input  1  character pixel opaque
- obst_red, obst_green, obst_blue  input  4 each  obstacle layer colour
- obst_visible  input  1  obstacle pixel opaque
- restart_key  input  1  synchronous level; restart request
- vga_red, vga_green, vga_blue  output  4 each  final colour, registered
- collision  output  1  one-cycle pulse on first overlap of a run
- game_over  output  1  high in OVER
- score  output  SCORE_W  frames survived

Behaviour:
- Reset (async, active-high): vga_* = 0; collision = 0; game_over = 0; score = 0; state = RUN; flash counter = 0; frame-start detector cleared.
- Pixel path: exactly 1 clock latency from inputs to vga_*. Priority, highest first:
  - visible == 0 -> 0,0,0.
  - char_visible -> char colour.
  - obst_visible -> obst colour.
  - otherwise -> BG_COLOR.
- Frame start (fs): rising edge of (display_col == 0 && display_row == 0). Exactly one fs per frame, even if the condition holds for several clocks.
- Overlap: visible && char_visible && obst_visible in the same cycle.
- RUN:
  - Each fs: score += 1, saturating at all-ones with no wrap.
  - Overlap -> collision = 1 on the next clock, for one cycle; load flash counter with HIT_FLASH_FRAMES; go to HIT.
  - If fs and overlap occur in the same cycle, the score increment still occurs.
- HIT:
  - Score frozen; further overlaps produce no collision pulse.
  - Each fs decrements the flash counter.
  - While the counter's bit 2 = 1, character pixels are drawn as pure red (F,0,0) instead of char colour. This gives the flash effect.
  - Counter reaching 0 on an fs -> OVER.
- OVER:
  - game_over = 1; score frozen; overlaps ignored.
  - restart_key == 1 -> RUN next clock with score = 0 and game_over = 0.
  - restart_key is ignored in RUN and HIT.
- Colour packing: all colour fields are passed through unmodified, with no arithmetic. BG_COLOR is split as red = [3:0], green = [7:4], blue = [11:8].
- Reset asserted mid-frame or mid-HIT: immediate return to reset values. The first fs after release counts normally.

Optional Feature:
- Macro HIGH_SCORE_EN.
- Defined:
  - Adds output port high_score [SCORE_W-1:0], reset to 0.
  - On the RUN/HIT -> OVER transition clock, high_score <= score if score > high_score.
  - Not cleared by restart_key; cleared only by reset.
- Undefined: port and register are absent. All other behaviour is identical.

Test Plan:
- Priority: visible = 1, char_visible = 1 char = (3,5,7), obst_visible = 1 obst = (9,9,9) -> next clock vga = (3,5,7). Drop char_visible -> (9,9,9). Drop both -> (F,F,F). visible = 0 -> (0,0,0).
- Scoring: 5 frames in RUN with no overlap, and (0,0) held 3 clocks per frame -> score = 5 (not 15). Preload to 16'hFFFF via long run or force -> stays FFFF.
- Collision: overlap at col 300, row 600, then 10 more overlap pixels -> exactly one collision pulse one clock after the first. State HIT; score frozen.
- HIT timing: HIT_FLASH_FRAMES = 4 -> game_over rises on the 4th fs after the collision. Character pixels are red when counter bit 2 = 1 (count 4), normal colour at counts 3..1.
- Restart: in OVER, pulse restart_key -> next clock game_over = 0, score = 0, state RUN. restart_key during RUN -> no effect. Reset asserted mid-HIT -> all outputs 0 immediately.
- HIGH_SCORE_EN: game 1 ends at score 12 -> high_score = 12. Game 2 ends at 7 -> stays 12. Game 3 ends at 20 -> 20. Reset -> 0.
